shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 n_reset  input  1  reset, asynchronous, active-low; clock clk.
REQ-004 start  input  1  request to begin a multiply; honoured only when busy=0.
REQ-005 abort  input  1  synchronous cancel of the operation in progress.
REQ-006 multiplicand  input  WIDTH  operand A, sampled on the accepted start edge.
REQ-007 multiplier  input  WIDTH  operand B, sampled on the accepted start edge.
REQ-008 busy  output  1  high while state is RUN.
REQ-009 done  output  1  one-cycle pulse; product valid while high.
REQ-010 product  output  2*WIDTH  unsigned result A*B, held until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-012 Internal accumulator SHALL be 2*WIDTH+1 bits (carry, upper WIDTH, lower WIDTH); A SHALL be held in its own WIDTH-bit register.
REQ-013 IDLE with start=1 SHALL load accumulator={0, zeros, multiplier}, latch A, clear the iteration counter, go to RUN.
REQ-014 Each RUN edge SHALL add A to the upper half when accumulator bit 0 is 1 (else add 0), then shift the (WIDTH+1)-bit sum concatenated with lower[WIDTH-1:1] right by one, all in the same cycle.
REQ-015 The counter SHALL be ceil(log2(WIDTH+1)) bits; after WIDTH RUN edges the FSM SHALL go to DONE.
REQ-016 Latency: start sampled at edge 0 -> done=1 after edge WIDTH, for exactly one cycle; DONE SHALL return to IDLE on the next edge.
REQ-017 product SHALL equal accumulator[2*WIDTH-1:0]; it SHALL be updated only at the DONE transition and otherwise hold its value (not reflect intermediate RUN values).
REQ-018 start while busy=1 or during DONE SHALL be ignored; operands and state unaffected.
REQ-019 start asserted in the same cycle as done SHALL be ignored; a new start is accepted from IDLE only.
REQ-020 abort=1 in RUN SHALL return to IDLE on that edge, with no done pulse and product unchanged; abort has priority over iteration.
REQ-021 abort in IDLE or DONE SHALL have no effect; DONE still pulses and then returns to IDLE.
REQ-022 abort and start together in IDLE SHALL accept the start (abort ignored).
REQ-023 Arithmetic is unsigned; no overflow is possible since the product fits in 2*WIDTH bits.

Reset
REQ-024 n_reset low SHALL immediately force state=IDLE, busy=0, done=0, product=0, accumulator=0, A=0, counter=0, regardless of clk.
REQ-025 Reset mid-RUN SHALL discard the operation; after release the block SHALL accept a new start on the first edge.

Verification
REQ-026 WIDTH=8: start, A=13, B=11 -> busy for 8 cycles, done pulse 8 cycles after start edge, product=143.
REQ-027 WIDTH=8: A=255, B=255 -> product=65025 (0xFE01); carry path exercised.
REQ-028 WIDTH=8: A=0, B=200, then A=200, B=0 -> product=0 both times, done still pulses at latency 8.
REQ-029 WIDTH=8: A=7, B=9 running, start with A=3, B=3 on cycle 3 -> ignored, product=63; abort on cycle 4 of a second op -> no done, product stays 63.
REQ-030 n_reset pulsed low asynchronously mid-RUN -> outputs 0 at once; new start A=5, B=6 after release -> product=30.
REQ-031 WIDTH=16: randomised 1000 operand pairs -> each product matches the reference A*B, done latency 16.

Source files
------------

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned shift-and-add multiplier.
//
// One partial-product bit is retired per clock, so a WIDTH-bit multiply
// takes WIDTH RUN cycles. The accumulator is {carry, upper, lower}; the
// multiplier starts in lower and is shifted out LSB first. The product
// bits shift in from the top at the same time.
//
// Ports
//   clk           rising-edge clock
//   n_reset       asynchronous active-low reset
//   start         begin a multiply (accepted in IDLE only)
//   abort         cancel the multiply in progress (RUN only)
//   multiplicand  operand A, sampled on the accepted start edge
//   multiplier    operand B, sampled on the accepted start edge
//   busy          high while in RUN
//   done          one-cycle pulse; product is valid while high
//   product       A*B, held until the next completed multiply
module shift_add_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [2*WIDTH:0]    acc;
  logic [2*WIDTH:0]    acc_step;
  logic [WIDTH-1:0]    a_reg;
  logic [CW-1:0]       cnt;
  logic [WIDTH:0]      sum;
  logic                last;

  // The current RUN edge is the WIDTH-th one.
  assign last = (cnt == CW'(WIDTH - 1));

  // Conditional add into the upper half, then shift {sum, lower} right by one.
  // The LSB of lower is dropped, having just been consumed.
  always_comb begin
    sum      = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, a_reg} : '0);
    acc_step = {1'b0, sum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The product register is written only on the RUN->DONE edge, so partial
  // sums never appear on the output, and an abort leaves the old result.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc     <= '0;
      a_reg   <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          acc   <= {1'b0, {WIDTH{1'b0}}, multiplier};
          a_reg <= multiplicand;
          cnt   <= '0;
        end
        RUN: if (!abort) begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
          if (last) product <= acc_step[2*WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed plus randomized bench for shift_add_mult.
// An 8-bit instance covers the directed scenarios. A 16-bit instance takes
// random operand pairs. The expected results are plain A*B products, and the
// expected timing is a fixed WIDTH-cycle latency counted from the start edge.
module tb_shift_add_mult;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;

  logic        s8 = 0, ab8 = 0;
  logic [7:0]  a8 = 0, b8 = 0;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        s16 = 0, ab16 = 0;
  logic [15:0] a16 = 0, b16 = 0;
  logic        busy16, done16;
  logic [31:0] prod16;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] hold8  = '0;
  logic [31:0] hold16 = '0;

  always #5 clk = ~clk;

  shift_add_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .n_reset(n_reset), .start(s8), .abort(ab8),
    .multiplicand(a8), .multiplier(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  shift_add_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .n_reset(n_reset), .start(s16), .abort(ab16),
    .multiplicand(a16), .multiplier(b16),
    .busy(busy16), .done(done16), .product(prod16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One 8-bit multiply. abort_at: RUN edge (1..8) to abort on, 0 for none.
  // stray_at: RUN edge before which a competing start (3*3) is raised, 0 for none.
  // poke_done: raise start+abort during the done cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b,
                      input int abort_at, input int stray_at, input bit poke_done,
                      input bit abort_with_start);
    @(negedge clk);
    s8 = 1; a8 = a; b8 = b; ab8 = abort_with_start;
    @(posedge clk); #1;
    s8 = 0; ab8 = 0; a8 = 8'hxx; b8 = 8'hxx;
    check("busy8_after_start", 64'(busy8), 64'd1);
    for (int k = 1; k <= 8; k++) begin
      if (k == abort_at) ab8 = 1;
      if (k == stray_at) begin s8 = 1; a8 = 3; b8 = 3; end
      @(posedge clk); #1;
      s8 = 0; ab8 = 0;
      if (k == abort_at) begin
        check("busy8_abort", 64'(busy8), 64'd0);
        check("done8_abort", 64'(done8), 64'd0);
        check("prod8_abort", 64'(prod8), 64'(hold8));
        @(posedge clk); #1;
        check("done8_after_abort", 64'(done8), 64'd0);
        return;
      end
      if (k < 8) begin
        check("busy8_run", 64'(busy8), 64'd1);
        check("done8_run", 64'(done8), 64'd0);
        check("prod8_hold", 64'(prod8), 64'(hold8));
      end else begin
        hold8 = 16'(a) * 16'(b);
        check("done8_latency", 64'(done8), 64'd1);
        check("busy8_done", 64'(busy8), 64'd0);
        check("prod8", 64'(prod8), 64'(hold8));
      end
    end
    if (poke_done) begin s8 = 1; ab8 = 1; a8 = 8'd1; b8 = 8'd1; end
    @(posedge clk); #1;
    s8 = 0; ab8 = 0;
    check("done8_one_cycle", 64'(done8), 64'd0);
    check("busy8_idle", 64'(busy8), 64'd0);
    check("prod8_held", 64'(prod8), 64'(hold8));
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    s16 = 1; a16 = a; b16 = b;
    @(posedge clk); #1;
    s16 = 0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        if (done16 !== 1'b0 || busy16 !== 1'b1) check("ctl16_run", {62'd0, busy16, done16}, 64'd2);
      end else begin
        hold16 = 32'(a) * 32'(b);
        check("done16_latency", 64'(done16), 64'd1);
        check("prod16", 64'(prod16), 64'(hold16));
      end
    end
    @(posedge clk); #1;
    check("done16_one_cycle", 64'(done16), 64'd0);
  endtask

  initial begin
    // Reset state
    #7;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", 64'(prod8), 64'd0);
    check("rst_prod16", 64'(prod16), 64'd0);
    @(negedge clk); n_reset = 1;

    // Basic, carry path, zero operands
    run8(8'd13, 8'd11, 0, 0, 0, 0);
    run8(8'd255, 8'd255, 0, 0, 0, 0);
    check("prod8_fe01", 64'(prod8), 64'hFE01);
    run8(8'd0, 8'd200, 0, 0, 0, 0);
    run8(8'd200, 8'd0, 0, 0, 0, 0);

    // Start mid-run ignored; start+abort during DONE ignored
    run8(8'd7, 8'd9, 0, 3, 1, 0);
    check("prod8_63", 64'(prod8), 64'd63);
    // Abort on cycle 4 of the next op: no done, product stays 63
    run8(8'd10, 8'd10, 4, 0, 0, 0);
    check("prod8_after_abort", 64'(prod8), 64'd63);
    // Abort together with start in IDLE: start wins
    run8(8'd17, 8'd3, 0, 0, 0, 1);

    // Asynchronous reset mid-run
    @(negedge clk);
    s8 = 1; a8 = 8'd99; b8 = 8'd77;
    @(posedge clk); #1; s8 = 0;
    repeat (3) @(posedge clk);
    #3 n_reset = 0;
    #1;
    check("arst_busy8", 64'(busy8), 64'd0);
    check("arst_done8", 64'(done8), 64'd0);
    check("arst_prod8", 64'(prod8), 64'd0);
    hold8 = '0; hold16 = '0;
    @(negedge clk); n_reset = 1;
    run8(8'd5, 8'd6, 0, 0, 0, 0);
    check("prod8_30", 64'(prod8), 64'd30);

    // Randomized 16-bit run, including the extreme pairs
    run16(16'hFFFF, 16'hFFFF);
    run16(16'h0000, 16'hFFFF);
    for (int i = 0; i < 1000; i++)
      run16(16'($urandom), 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
